dmem_arbiter: RTL and testbench

Shares the single data-memory port between the MIPS core and a debug/loader master. It sits between the core's data-side signals (`mem_write`, `alu_out`, `mem_write_data`, `mem_read_data`) and the data memory.
- Each access uses a 3-cycle request/grant/acknowledge sequence.
- Arbitration is round-robin, and a debug lock can force exclusive access.
- The core stalls until its access completes.
- A saturating wait counter measures the stall cycles the core sees.

---
 rtl/dmem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Shares one data-memory port between the CPU data side and a debug/loader
// master. Every access runs IDLE -> ACCESS -> RESP: the winner's request is
// latched in IDLE, driven to memory in ACCESS, and acknowledged in RESP.
// Ties are broken round-robin. dbg_lock reserves the port for the debug master.
// A saturating counter records how many cycles the CPU spent stalled.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cpu_*           CPU request/response (req held until ack)
//   cpu_stall       cpu_req & ~cpu_ack
//   dbg_*           debug master request/response, same protocol as cpu_*
//   dbg_lock        grant only the debug master while high (sampled in IDLE)
//   mem_*           data-memory port; mem_rdata is combinational from mem_addr
//   owner           00 none, 01 CPU, 10 debug
//   cpu_wait_cnt    saturating count of CPU stall cycles
module dmem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  input  logic          dbg_lock,

  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic [1:0]    owner,
  output logic [CW-1:0] cpu_wait_cnt
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e          state_q, state_d;
  logic            win_dbg_q, win_dbg_d;     // winner of the access in flight
  logic            last_dbg_q, last_dbg_d;   // last grant went to debug
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic [CW-1:0]   wait_q, wait_d;

  logic            grant_cpu, grant_dbg;

  // Arbitration decision, only consumed in IDLE.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (dbg_lock) begin
      grant_dbg = dbg_req;
    end else if (cpu_req && dbg_req) begin
      // Tie: serve whichever port was not granted last.
      if (last_dbg_q) begin
        grant_cpu = 1'b1;
      end else begin
        grant_dbg = 1'b1;
      end
    end else begin
      grant_cpu = cpu_req;
      grant_dbg = dbg_req;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    win_dbg_d   = win_dbg_q;
    last_dbg_d  = last_dbg_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    case (state_q)
      StIdle: begin
        if (grant_cpu) begin
          win_dbg_d  = 1'b0;
          last_dbg_d = 1'b0;
          we_d       = cpu_we;
          addr_d     = cpu_addr;
          wdata_d    = cpu_wdata;
          state_d    = StAccess;
        end else if (grant_dbg) begin
          win_dbg_d  = 1'b1;
          last_dbg_d = 1'b1;
          we_d       = dbg_we;
          addr_d     = dbg_addr;
          wdata_d    = dbg_wdata;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        // Read data is only captured for reads so rdata holds across writes.
        if (!we_q) begin
          if (win_dbg_q) begin
            dbg_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
        end
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs. rst gates the strobes so a reset landing in ACCESS or RESP
  // suppresses the write or ack in that same cycle.
  always_comb begin
    mem_we    = (state_q == StAccess) && we_q && !rst;
    mem_addr  = {addr_q[AW-1:2], 2'b00};
    mem_wdata = wdata_q;
    cpu_ack   = (state_q == StResp) && !win_dbg_q && !rst;
    dbg_ack   = (state_q == StResp) && win_dbg_q && !rst;
    cpu_stall = cpu_req && !cpu_ack;
    cpu_rdata = cpu_rdata_q;
    dbg_rdata = dbg_rdata_q;
    cpu_wait_cnt = wait_q;
    if (state_q == StIdle) begin
      owner = 2'b00;
    end else begin
      owner = win_dbg_q ? 2'b10 : 2'b01;
    end
  end

  // Saturating stall counter.
  always_comb begin
    wait_d = wait_q;
    if (cpu_stall && (wait_q != {CW{1'b1}})) begin
      wait_d = wait_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      win_dbg_q   <= 1'b0;
      last_dbg_q  <= 1'b1;  // first tie after reset goes to the CPU
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      win_dbg_q   <= win_dbg_d;
      last_dbg_q  <= last_dbg_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      wait_q      <= wait_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a 64-word memory model on the main instance,
// plus a CW=4 instance for counter saturation.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack, dbg_lock;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;
  logic [15:0] cpu_wait_cnt;

  // Saturation instance signals
  logic        s_cpu_req, s_cpu_ack, s_cpu_stall, s_dbg_req, s_dbg_ack, s_dbg_lock, s_mem_we;
  logic [31:0] s_cpu_rdata, s_dbg_rdata, s_mem_addr, s_mem_wdata;
  logic [1:0]  s_owner;
  logic [3:0]  s_cpu_wait_cnt;

  dmem_arbiter u_dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .cpu_stall    (cpu_stall),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_rdata    (dbg_rdata),
    .dbg_ack      (dbg_ack),
    .dbg_lock     (dbg_lock),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .owner        (owner),
    .cpu_wait_cnt (cpu_wait_cnt)
  );

  dmem_arbiter #(.CW(4)) u_sat (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (s_cpu_req),
    .cpu_we       (1'b0),
    .cpu_addr     (32'h0),
    .cpu_wdata    (32'h0),
    .cpu_rdata    (s_cpu_rdata),
    .cpu_ack      (s_cpu_ack),
    .cpu_stall    (s_cpu_stall),
    .dbg_req      (s_dbg_req),
    .dbg_we       (1'b0),
    .dbg_addr     (32'h0),
    .dbg_wdata    (32'h0),
    .dbg_rdata    (s_dbg_rdata),
    .dbg_ack      (s_dbg_ack),
    .dbg_lock     (s_dbg_lock),
    .mem_we       (s_mem_we),
    .mem_addr     (s_mem_addr),
    .mem_wdata    (s_mem_wdata),
    .mem_rdata    (32'h0),
    .owner        (s_owner),
    .cpu_wait_cnt (s_cpu_wait_cnt)
  );

  // Memory model: combinational read, write on the rising edge.
  logic [31:0] mem [0:63];
  logic        mem_init;
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 4) ? 32'hDEADBEEF : 32'h0;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  // Pulse counters, sampled on the edge that ends each cycle.
  int we_cnt = 0, cack_cnt = 0, dack_cnt = 0;
  always @(posedge clk) begin
    if (mem_we)  we_cnt   <= we_cnt + 1;
    if (cpu_ack) cack_cnt <= cack_cnt + 1;
    if (dbg_ack) dack_cnt <= dack_cnt + 1;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Cycles (negedges) until the chosen ack is seen; 99 if it never comes.
  task automatic wait_ack(input bit dbg, output int n);
    n = 99;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (dbg ? dbg_ack : cpu_ack) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int n, we0, ca0;

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
    s_cpu_req = 0; s_dbg_req = 0; s_dbg_lock = 0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_cpu_ack", {31'b0, cpu_ack}, 32'h0);
    check("rst_dbg_ack", {31'b0, dbg_ack}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_owner", {30'b0, owner}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_dbg_rdata", dbg_rdata, 32'h0);
    check("rst_wait_cnt", {16'b0, cpu_wait_cnt}, 32'h0);
    rst = 1'b0; mem_init = 1'b0;

    // CPU read of 0x10
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    wait_ack(1'b0, n);
    check("rd_latency", n, 2);
    check("rd_data", cpu_rdata, 32'hDEADBEEF);
    check("rd_wait_cnt", {16'b0, cpu_wait_cnt}, 32'd2);
    cpu_req = 0;
    @(negedge clk);

    // Tie: CPU write and debug read of 0x20 raised together, after reset
    pulse_reset();
    we0 = we_cnt;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hA5A5A5A5;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
    @(negedge clk);
    check("tie_owner_cpu", {30'b0, owner}, 32'h1);
    check("tie_mem_we", {31'b0, mem_we}, 32'h1);
    check("tie_mem_addr", mem_addr, 32'h20);
    check("tie_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    @(negedge clk);
    check("tie_cpu_ack", {31'b0, cpu_ack}, 32'h1);
    check("tie_dbg_ack_low", {31'b0, dbg_ack}, 32'h0);
    cpu_req = 0;
    wait_ack(1'b1, n);
    check("tie_dbg_after", n, 3);
    check("tie_owner_dbg", {30'b0, owner}, 32'h2);
    check("tie_dbg_rdata", dbg_rdata, 32'hA5A5A5A5);
    check("tie_we_pulses", we_cnt - we0, 1);
    dbg_req = 0;
    @(negedge clk);

    // Debug lock: 4 back-to-back debug writes while CPU waits
    ca0 = cack_cnt;
    dbg_lock = 1; dbg_req = 1; dbg_we = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 32'(4 * i);
      dbg_wdata = 32'hC0DE0000 + 32'(i);
      wait_ack(1'b1, n);
      check($sformatf("lock_gap%0d", i), n, (i == 0) ? 2 : 3);
    end
    dbg_lock = 0; dbg_req = 0;
    check("lock_no_cpu_ack", cack_cnt - ca0, 0);
    check("lock_mem3", mem[3], 32'hC0DE0003);
    wait_ack(1'b0, n);
    check("unlock_cpu_lat", n, 3);
    check("unlock_cpu_rdata", cpu_rdata, 32'hC0DE0001);
    check("unlock_wait_cnt", {16'b0, cpu_wait_cnt}, 32'd16);
    cpu_req = 0;
    @(negedge clk);

    // Unaligned read at 0x23
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h23;
    @(negedge clk);
    check("unal_mem_addr", mem_addr, 32'h20);
    check("unal_mem_we", {31'b0, mem_we}, 32'h0);
    wait_ack(1'b0, n);
    check("unal_lat", n, 1);
    check("unal_rdata", cpu_rdata, 32'hA5A5A5A5);
    cpu_req = 0;
    @(negedge clk);

    // Reset during the ACCESS cycle of a CPU write
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h24; cpu_wdata = 32'h12345678;
    @(negedge clk);
    check("rw_mem_we_pre", {31'b0, mem_we}, 32'h1);
    we0 = we_cnt; ca0 = cack_cnt;
    rst = 1'b1;
    #1;
    check("rw_mem_we_rst", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    check("rw_no_ack", {31'b0, cpu_ack}, 32'h0);
    check("rw_owner", {30'b0, owner}, 32'h0);
    check("rw_mem_unchanged", mem[9], 32'h0);
    check("rw_no_we_pulse", we_cnt - we0, 0);
    check("rw_mem_addr", mem_addr, 32'h0);
    rst = 1'b0; cpu_req = 0;
    @(negedge clk);
    check("rw_no_ack_later", cack_cnt - ca0, 0);

    // Counter saturation on the CW=4 instance
    s_dbg_lock = 1; s_cpu_req = 1;
    repeat (14) @(negedge clk);
    check("sat_14", {28'b0, s_cpu_wait_cnt}, 32'd14);
    @(negedge clk);
    check("sat_15", {28'b0, s_cpu_wait_cnt}, 32'd15);
    repeat (5) @(negedge clk);
    check("sat_hold", {28'b0, s_cpu_wait_cnt}, 32'd15);
    check("sat_no_ack", {31'b0, s_cpu_ack}, 32'h0);
    check("sat_owner", {30'b0, s_owner}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
